// File: rtl/regfile_pkg.sv
// Shared sizing constants and the write-hit helper used by the register file
// read ports.
package regfile_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_WIDTH  = 32;
  localparam int ADDR_WIDTH = 5;
  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

  // True when a read address lands on a register that is being written in
  // this same cycle; reset and writes to r0 never count as a hit.
  function automatic logic isWriteHit(
    input logic                  writeEnable,
    input logic                  reset,
    input logic [ADDR_WIDTH-1:0] writeAddr,
    input logic [ADDR_WIDTH-1:0] readAddr
  );
    return writeEnable && !reset && (writeAddr != ZERO_REG) && (readAddr == writeAddr);
  endfunction

endpackage

// File: rtl/decode5to32.sv
// Binary-to-one-hot decoder: a 5-bit select drives exactly one of 32 outputs.
module decode5to32 (
  input  logic [4:0]  select_i,
  output logic [31:0] onehot_o
);

  assign onehot_o = 32'(1) << select_i;

endmodule

// File: rtl/regfile_register32.sv
// One 32-bit architectural register with synchronous clear and load enable.
module register32
  import regfile_pkg::*;
(
  input  logic                 clock,
  input  logic                 ctrl_reset,
  input  logic                 enable_i,
  input  logic [REG_WIDTH-1:0] data_i,
  output logic [REG_WIDTH-1:0] data_o
);

  logic [REG_WIDTH-1:0] data_q;
  logic [REG_WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (enable_i) data_d = data_i;
  end

  // Clear takes priority so a write issued during reset is dropped.
  always_ff @(posedge clock) begin
    if (ctrl_reset) data_q <= '0;
    else            data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/regfile.sv
// 32x32 architectural register file: one write port, two combinational read
// ports, r0 hardwired to zero, optional same-cycle write-to-read bypass.
module regfile
  import regfile_pkg::*;
#(
  parameter bit BYPASS = 1'b0
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  input  logic [REG_WIDTH-1:0]  data_writeReg,
  output logic [REG_WIDTH-1:0]  data_readRegA,
  output logic [REG_WIDTH-1:0]  data_readRegB
);

  logic [REG_COUNT-1:0] decodedWrite;
  logic [REG_COUNT-1:0] writeEnables;
  logic [REG_WIDTH-1:0] regData [REG_COUNT];
  logic                 unusedZeroEnable;
  logic                 hitA;
  logic                 hitB;

  decode5to32 u_decode (
    .select_i (ctrl_writeReg),
    .onehot_o (decodedWrite)
  );

  assign writeEnables     = decodedWrite & {REG_COUNT{ctrl_writeEnable}};
  assign unusedZeroEnable = writeEnables[0];

  // r0 has no storage; only r1..r31 get a physical register.
  assign regData[0] = '0;

  for (genvar i = 1; i < REG_COUNT; i++) begin : gen_regs
    register32 u_reg (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .enable_i   (writeEnables[i]),
      .data_i     (data_writeReg),
      .data_o     (regData[i])
    );
  end

  assign hitA = BYPASS && isWriteHit(ctrl_writeEnable, ctrl_reset, ctrl_writeReg, ctrl_readRegA);
  assign hitB = BYPASS && isWriteHit(ctrl_writeEnable, ctrl_reset, ctrl_writeReg, ctrl_readRegB);

  always_comb begin
    data_readRegA = regData[ctrl_readRegA];
    if (hitA) data_readRegA = data_writeReg;
  end

  always_comb begin
    data_readRegB = regData[ctrl_readRegB];
    if (hitB) data_readRegB = data_writeReg;
  end

endmodule
